grf_hazard_ctrl: RTL and testbench

- Decode-stage hazard controller for the 5-stage pipelined MIPS core.
- Tracks in-flight register-file writes in the E, M and W stages in a 3-deep shadow pipeline of {valid, write address, Tnew}.
- Decides whether the instruction in D must stall.
- Selects the forwarding source for each of the two GRF read ports.
- Counts stall cycles for debug.

---
 rtl/grf_hazard_ctrl_pkg.sv | 32 +++
 rtl/grf_hazard_ctrl_if.sv | 39 +++
 rtl/grf_hazard_ctrl_src_check.sv | 42 ++++
 rtl/grf_hazard_ctrl.sv | 76 +++++++
 tb/tb_grf_hazard_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/grf_hazard_ctrl_pkg.sv
// Shared hazard-control types: forward encodings, Tnew/Tuse constants
// and the in-flight write entry.
package hazard_pkg;

    localparam int GRF_AW = 5;
    localparam int GRF_TW = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam logic [GRF_TW-1:0] T_ALU           = 2'd1;
    localparam logic [GRF_TW-1:0] T_LOAD          = 2'd2;
    localparam logic [GRF_TW-1:0] T_LINK          = 2'd0;
    localparam logic [GRF_TW-1:0] TUSE_BR         = 2'd0;
    localparam logic [GRF_TW-1:0] TUSE_ALU        = 2'd1;
    localparam logic [GRF_TW-1:0] TUSE_STORE_DATA = 2'd2;

    typedef struct packed {
        logic              v;
        logic [GRF_AW-1:0] wa;
        logic [GRF_TW-1:0] tnew;
    } hz_entry_t;

    function automatic logic [GRF_TW-1:0] tnew_dec(
        input logic [GRF_TW-1:0] t
    );
        return (t == '0) ? '0 : t - GRF_TW'(1);
    endfunction

endpackage

// File: rtl/grf_hazard_ctrl_if.sv
// Decode-side bundle between the D stage and the hazard controller.
interface grf_hazard_ctrl_if #(
    parameter int AW = 5,
    parameter int TW = 2,
    parameter int CW = 32
);
    logic          d_valid;
    logic [AW-1:0] d_wa;
    logic [TW-1:0] d_tnew;
    logic [AW-1:0] rs_addr;
    logic [TW-1:0] rs_tuse;
    logic          rs_used;
    logic [AW-1:0] rt_addr;
    logic [TW-1:0] rt_tuse;
    logic          rt_used;
    logic          stall;
    logic [1:0]    fwd_rs;
    logic [1:0]    fwd_rt;
    logic [AW-1:0] e_wa;
    logic [AW-1:0] m_wa;
    logic [AW-1:0] w_wa;
    logic [CW-1:0] stall_cnt;

    modport master (
        output d_valid, d_wa, d_tnew,
        output rs_addr, rs_tuse, rs_used,
        output rt_addr, rt_tuse, rt_used,
        input  stall, fwd_rs, fwd_rt,
        input  e_wa, m_wa, w_wa, stall_cnt
    );

    modport slave (
        input  d_valid, d_wa, d_tnew,
        input  rs_addr, rs_tuse, rs_used,
        input  rt_addr, rt_tuse, rt_used,
        output stall, fwd_rs, fwd_rt,
        output e_wa, m_wa, w_wa, stall_cnt
    );
endinterface

// File: rtl/grf_hazard_ctrl_src_check.sv
// Per-read-port check: youngest matching in-flight write decides
// stall vs. forward source.
import hazard_pkg::*;

module hz_src_check (
    input  hz_entry_t         e,
    input  hz_entry_t         m,
    input  hz_entry_t         w,
    input  logic [GRF_AW-1:0] addr,
    input  logic [GRF_TW-1:0] tuse,
    input  logic              used,
    output logic              stall_req,
    output logic [1:0]        fwd_sel
);
    logic          live;
    logic          hit_e;
    logic          hit_m;
    logic          hit_w;
    logic [GRF_TW-1:0] t;
    logic [1:0]    idx;

    assign live  = used && (addr != '0);
    assign hit_e = live && e.v && (e.wa == addr);
    assign hit_m = live && m.v && (m.wa == addr) && !hit_e;
    assign hit_w = live && w.v && (w.wa == addr)
                   && !hit_e && !hit_m;

    always_comb begin
        t   = '0;
        idx = FWD_GRF;
        unique case (1'b1)
            hit_e: begin t = e.tnew; idx = FWD_E; end
            hit_m: begin t = m.tnew; idx = FWD_M; end
            hit_w: begin t = w.tnew; idx = FWD_W; end
            default: ;
        endcase
    end

    // Non-zero tnew within tuse: consumer picks it up further down.
    assign stall_req = (idx != FWD_GRF) && (t > tuse);
    assign fwd_sel   = (t == '0) ? idx : FWD_GRF;
endmodule

// File: rtl/grf_hazard_ctrl.sv
// Decode-stage hazard controller: shadow E/M/W write tracking,
// stall decision, forward select and stall counter.
import hazard_pkg::*;

module grf_hazard_ctrl #(
    parameter int AW = GRF_AW,
    parameter int TW = GRF_TW,
    parameter int CW = 32
) (
    input logic               clk,
    input logic               reset,
    grf_hazard_ctrl_if.slave  bus
);
    hz_entry_t     e_q, m_q, w_q;
    hz_entry_t     e_nxt, m_nxt, w_nxt;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] d_wa;
    logic [TW-1:0] d_tnew;
    logic          rs_stall, rt_stall;
    logic          stall;
    logic          issue;

    assign d_wa   = bus.d_wa;
    assign d_tnew = bus.d_tnew;

    hz_src_check u_rs (
        .e(e_q), .m(m_q), .w(w_q),
        .addr(bus.rs_addr), .tuse(bus.rs_tuse),
        .used(bus.rs_used),
        .stall_req(rs_stall), .fwd_sel(bus.fwd_rs)
    );

    hz_src_check u_rt (
        .e(e_q), .m(m_q), .w(w_q),
        .addr(bus.rt_addr), .tuse(bus.rt_tuse),
        .used(bus.rt_used),
        .stall_req(rt_stall), .fwd_sel(bus.fwd_rt)
    );

    assign stall = bus.d_valid && (rs_stall || rt_stall);
    assign issue = bus.d_valid && !stall && (d_wa != '0);

    always_comb begin
        e_nxt = '0;
        if (issue) begin
            e_nxt.v    = 1'b1;
            e_nxt.wa   = d_wa;
            e_nxt.tnew = d_tnew;
        end
        m_nxt      = e_q;
        m_nxt.tnew = tnew_dec(e_q.tnew);
        w_nxt      = m_q;
        w_nxt.tnew = tnew_dec(m_q.tnew);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q <= e_nxt;
            m_q <= m_nxt;
            w_q <= w_nxt;
            if (stall && (cnt_q != '1))
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.stall     = stall;
    assign bus.e_wa      = e_q.v ? e_q.wa : '0;
    assign bus.m_wa      = m_q.v ? m_q.wa : '0;
    assign bus.w_wa      = w_q.v ? w_q.wa : '0;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Bench: age-based model of in-flight writes checked every cycle,
// plus directed literal checks for the key hazard scenarios.
module tb_grf_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    grf_hazard_ctrl_if #(.AW(5), .TW(2), .CW(4)) bus ();

    grf_hazard_ctrl #(.AW(5), .TW(2), .CW(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Model: hist[k] is the instruction issued k+1 edges ago
    // (0=E,1=M,2=W); remaining latency is issue tnew minus age.
    typedef struct {
        bit v;
        int wa;
        int t0;
    } mi_t;

    mi_t hist[3];
    int  mcnt = 0;

    function automatic void src(input int a, input int tu, input bit used,
                                output bit st, output int fw);
        int rem;
        st = 1'b0;
        fw = 0;
        if (!used || a == 0) return;
        for (int s = 0; s < 3; s++) begin
            if (hist[s].v && hist[s].wa == a) begin
                rem = hist[s].t0 - s;
                if (rem < 0) rem = 0;
                st = rem > tu;
                fw = (rem == 0) ? s + 1 : 0;
                return;
            end
        end
    endfunction

    function automatic void model(output bit st, output int fr,
                                  output int ft);
        bit s1, s2;
        src(int'(bus.rs_addr), int'(bus.rs_tuse), bus.rs_used, s1, fr);
        src(int'(bus.rt_addr), int'(bus.rt_tuse), bus.rt_used, s2, ft);
        st = bus.d_valid && (s1 || s2);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        bit st;
        int fr, ft;
        if (reset) begin
            for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
            mcnt = 0;
        end else begin
            model(st, fr, ft);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0].v  = bus.d_valid && !st && bus.d_wa != 0;
            hist[0].wa = hist[0].v ? int'(bus.d_wa) : 0;
            hist[0].t0 = hist[0].v ? int'(bus.d_tnew) : 0;
            if (st && mcnt < 15) mcnt++;
        end
    end

    always @(negedge clk) begin
        bit st;
        int fr, ft;
        if (chk_en) begin
            model(st, fr, ft);
            chk("stall", int'(bus.stall), int'(st));
            if (!st) begin
                chk("fwd_rs", int'(bus.fwd_rs), fr);
                chk("fwd_rt", int'(bus.fwd_rt), ft);
            end
            chk("e_wa", int'(bus.e_wa), hist[0].v ? hist[0].wa : 0);
            chk("m_wa", int'(bus.m_wa), hist[1].v ? hist[1].wa : 0);
            chk("w_wa", int'(bus.w_wa), hist[2].v ? hist[2].wa : 0);
            chk("stall_cnt", int'(bus.stall_cnt), mcnt);
        end
    end

    task automatic cyc(input bit v, input int wa, input int tn,
                       input int rsa, input int rst, input bit rsu,
                       input int rta, input int rtt, input bit rtu);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.d_valid  = v;
        bus.d_wa     = 5'(wa);
        bus.d_tnew   = 2'(tn);
        bus.rs_addr  = 5'(rsa);
        bus.rs_tuse  = 2'(rst);
        bus.rs_used  = rsu;
        bus.rt_addr  = 5'(rta);
        bus.rt_tuse  = 2'(rtt);
        bus.rt_used  = rtu;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        bus.d_valid = 1'b0;
        bus.d_wa    = '0;
        bus.d_tnew  = '0;
        bus.rs_addr = '0;
        bus.rs_tuse = '0;
        bus.rs_used = 1'b0;
        bus.rt_addr = '0;
        bus.rt_tuse = '0;
        bus.rt_used = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_stall", int'(bus.stall), 0);
        chk("rst_cnt", int'(bus.stall_cnt), 0);
        chk("rst_fwd_rs", int'(bus.fwd_rs), 0);
        chk("rst_e_wa", int'(bus.e_wa), 0);

        // ALU -> dependent ALU
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 4, 1, 3, 1, 1, 0, 0, 0);
        chk("alu_e_stall", int'(bus.stall), 0);
        chk("alu_e_fwd", int'(bus.fwd_rs), 0);
        cyc(1, 0, 0, 3, 1, 1, 4, 1, 1);
        chk("alu_m_fwd", int'(bus.fwd_rs), 2);
        chk("alu_e_fwd_rt", int'(bus.fwd_rt), 0);

        // Load-use
        cyc(1, 5, 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 5, 1, 1);
        chk("lu_stall", int'(bus.stall), 1);
        chk("lu_e_wa", int'(bus.e_wa), 5);
        cyc(1, 0, 0, 0, 0, 0, 5, 1, 1);
        chk("lu_release", int'(bus.stall), 0);
        chk("lu_cnt", int'(bus.stall_cnt), 1);
        chk("lu_fwd_rt", int'(bus.fwd_rt), 0);
        chk("lu_m_wa", int'(bus.m_wa), 5);
        cyc(1, 0, 0, 5, 0, 1, 0, 0, 0);
        chk("lu_w_fwd", int'(bus.fwd_rs), 3);

        // Branch on load
        cyc(1, 7, 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 7, 0, 1, 0, 0, 0);
        chk("br_stall1", int'(bus.stall), 1);
        cyc(1, 0, 0, 7, 0, 1, 0, 0, 0);
        chk("br_stall2", int'(bus.stall), 1);
        chk("br_cnt2", int'(bus.stall_cnt), 2);
        cyc(1, 0, 0, 7, 0, 1, 0, 0, 0);
        chk("br_go", int'(bus.stall), 0);
        chk("br_fwd_w", int'(bus.fwd_rs), 3);
        chk("br_cnt3", int'(bus.stall_cnt), 3);

        // Same register in E and M: E wins
        cyc(1, 9, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 9, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 9, 0, 1, 0, 0, 1);
        chk("prio_stall", int'(bus.stall), 1);
        cyc(1, 0, 0, 0, 0, 1, 9, 0, 1);
        chk("zero_stall", int'(bus.stall), 0);
        chk("zero_fwd", int'(bus.fwd_rs), 0);
        chk("m_fwd_rt", int'(bus.fwd_rt), 2);

        // d_valid masks the stall
        cyc(1, 10, 2, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 10, 0, 1);
        chk("mask_stall", int'(bus.stall), 0);
        cyc(1, 0, 0, 0, 0, 0, 10, 0, 1);
        chk("m_stall", int'(bus.stall), 1);

        // Reset mid-operation
        cyc(1, 11, 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 11, 1, 1, 0, 0, 0);
        chk("pre_rst_stall", int'(bus.stall), 1);
        chk("pre_rst_cnt", int'(bus.stall_cnt), 5);
        reset = 1'b1;
        cyc(1, 0, 0, 11, 1, 1, 0, 0, 0);
        chk("post_rst_stall", int'(bus.stall), 0);
        chk("post_rst_e", int'(bus.e_wa), 0);
        chk("post_rst_m", int'(bus.m_wa), 0);
        chk("post_rst_w", int'(bus.w_wa), 0);
        chk("post_rst_cnt", int'(bus.stall_cnt), 0);

        // Repeated load/branch on same reg drives the counter to saturation
        for (int i = 0; i < 30; i++)
            cyc(1, 12, 2, 12, 0, 1, 0, 0, 0);
        chk("sat_cnt", int'(bus.stall_cnt), 15);

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
